// File: rtl/alarm_sequencer_if.sv
// ---------------------------------------------------------------------------
// alarm_sequencer_if
//   Bundles the alarm sequencer's control inputs and status outputs. Clock and
//   reset stay as plain ports on the sequencer.
//
//   master : the side that drives ticks, switches, times and button pulses,
//            and observes the sequencer status.
//   slave  : the sequencer itself.
//
//   Signals
//     tick_1hz     one-clk pulse once per second
//     alarm_en     alarm enable switch (level)
//     current      current time, HHMM packed BCD
//     alarm        alarm time, HHMM packed BCD
//     push_m       stop request, one-clk pulse
//     push_snooze  snooze request, one-clk pulse
//     game_done    minigame success, one-clk pulse
//     alarm_state  FSM state encoding
//     ring         buzzer/LED enable
//     game_en      minigame enable
//     snooze_cnt   snoozes taken in the current alarm event
//     sec_left     seconds remaining on the active timer
// ---------------------------------------------------------------------------
interface alarm_sequencer_if;
  logic        tick_1hz;
  logic        alarm_en;
  logic [15:0] current;
  logic [15:0] alarm;
  logic        push_m;
  logic        push_snooze;
  logic        game_done;
  logic [2:0]  alarm_state;
  logic        ring;
  logic        game_en;
  logic [1:0]  snooze_cnt;
  logic [7:0]  sec_left;

  modport master (
    output tick_1hz, alarm_en, current, alarm, push_m, push_snooze, game_done,
    input  alarm_state, ring, game_en, snooze_cnt, sec_left
  );

  modport slave (
    input  tick_1hz, alarm_en, current, alarm, push_m, push_snooze, game_done,
    output alarm_state, ring, game_en, snooze_cnt, sec_left
  );
endinterface

// File: rtl/alarm_sequencer.sv
// ---------------------------------------------------------------------------
// alarm_sequencer
//   Alarm clock sequencer: arms on the enable switch, rings when the current
//   time first becomes equal to the alarm time, supports a bounded number of
//   snoozes (manual or automatic on ring timeout), and requires a minigame to
//   be completed to stop the alarm for good.
//
//   Ports
//     clk    sole clock, rising edge
//     reset  asynchronous, active-low reset
//     bus    alarm_sequencer_if.slave (inputs, status outputs)
//
//   State | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | alarm disabled, all outputs quiet
//   ARMED | waiting for a rising edge of (current == alarm)
//   RING  | buzzer on, ring timeout running
//   GAME  | minigame enabled, game timeout running
//   SNOOZE| buzzer off, snooze countdown running
// ---------------------------------------------------------------------------
module alarm_sequencer #(
  parameter logic [7:0] SNOOZE_SEC   = 8'd5,
  parameter logic [1:0] MAX_SNOOZE   = 2'd3,
  parameter logic [7:0] RING_TIMEOUT = 8'd10,
  parameter logic [7:0] GAME_TIMEOUT = 8'd30
) (
  input logic                clk,
  input logic                reset,
  alarm_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_ARMED  = 3'b001,
    ST_RING   = 3'b010,
    ST_GAME   = 3'b011,
    ST_SNOOZE = 3'b100
  } alarm_state_e;

  alarm_state_e state_q;
  logic         ring_q;
  logic         game_en_q;
  logic [1:0]   snooze_cnt_q;
  logic [7:0]   sec_left_q;
  logic         match_d;

  logic         match;
  logic         match_rise;
  logic         expiry;
  logic         snooze_ok;
  logic [7:0]   sec_dec;

  assign match      = (bus.current == bus.alarm);
  assign match_rise = match & ~match_d;
  // Terminal count: the tick that takes the timer from 1 to 0.
  assign expiry     = bus.tick_1hz & (sec_left_q == 8'd1);
  assign snooze_ok  = (snooze_cnt_q < MAX_SNOOZE);
  assign sec_dec    = (bus.tick_1hz && sec_left_q != 8'd0) ? (sec_left_q - 8'd1)
                                                           : sec_left_q;

  // match_d resets high so that releasing reset while current == alarm does
  // not look like a fresh match edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match_d <= 1'b1;
    end else begin
      match_d <= match;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      ring_q       <= 1'b0;
      game_en_q    <= 1'b0;
      snooze_cnt_q <= 2'd0;
      sec_left_q   <= 8'd0;
    end else if (!bus.alarm_en) begin
      state_q      <= ST_IDLE;
      ring_q       <= 1'b0;
      game_en_q    <= 1'b0;
      snooze_cnt_q <= 2'd0;
      sec_left_q   <= 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q   <= ST_ARMED;
          ring_q    <= 1'b0;
          game_en_q <= 1'b0;
        end

        ST_ARMED: begin
          if (match_rise) begin
            state_q    <= ST_RING;
            ring_q     <= 1'b1;
            sec_left_q <= RING_TIMEOUT;
          end
        end

        ST_RING: begin
          if (bus.push_m) begin
            state_q    <= ST_GAME;
            ring_q     <= 1'b0;
            game_en_q  <= 1'b1;
            sec_left_q <= GAME_TIMEOUT;
          end else if ((bus.push_snooze || expiry) && snooze_ok) begin
            state_q      <= ST_SNOOZE;
            ring_q       <= 1'b0;
            snooze_cnt_q <= snooze_cnt_q + 2'd1;
            sec_left_q   <= SNOOZE_SEC;
          end else if (expiry) begin
            // Snoozes exhausted: keep ringing with a fresh timeout.
            sec_left_q <= RING_TIMEOUT;
          end else begin
            sec_left_q <= sec_dec;
          end
        end

        ST_SNOOZE: begin
          if (bus.push_m) begin
            state_q    <= ST_GAME;
            game_en_q  <= 1'b1;
            sec_left_q <= GAME_TIMEOUT;
          end else if (expiry) begin
            state_q    <= ST_RING;
            ring_q     <= 1'b1;
            sec_left_q <= RING_TIMEOUT;
          end else begin
            sec_left_q <= sec_dec;
          end
        end

        ST_GAME: begin
          if (bus.game_done) begin
            state_q      <= ST_ARMED;
            game_en_q    <= 1'b0;
            snooze_cnt_q <= 2'd0;
            sec_left_q   <= 8'd0;
          end else if (expiry) begin
            state_q    <= ST_RING;
            game_en_q  <= 1'b0;
            ring_q     <= 1'b1;
            sec_left_q <= RING_TIMEOUT;
          end else begin
            sec_left_q <= sec_dec;
          end
        end

        default: begin
          state_q      <= ST_IDLE;
          ring_q       <= 1'b0;
          game_en_q    <= 1'b0;
          snooze_cnt_q <= 2'd0;
          sec_left_q   <= 8'd0;
        end
      endcase
    end
  end

  assign bus.alarm_state = state_q;
  assign bus.ring        = ring_q;
  assign bus.game_en     = game_en_q;
  assign bus.snooze_cnt  = snooze_cnt_q;
  assign bus.sec_left    = sec_left_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
module tb_alarm_sequencer;

  localparam logic [2:0] S_IDLE   = 3'b000;
  localparam logic [2:0] S_ARMED  = 3'b001;
  localparam logic [2:0] S_RING   = 3'b010;
  localparam logic [2:0] S_GAME   = 3'b011;
  localparam logic [2:0] S_SNOOZE = 3'b100;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  alarm_sequencer_if bus ();

  alarm_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] st, input logic rg,
                         input logic ge, input logic [1:0] sc, input logic [7:0] sl);
    chk({tag, ".state"},      {29'd0, bus.alarm_state}, {29'd0, st});
    chk({tag, ".ring"},       {31'd0, bus.ring},        {31'd0, rg});
    chk({tag, ".game_en"},    {31'd0, bus.game_en},     {31'd0, ge});
    chk({tag, ".snooze_cnt"}, {30'd0, bus.snooze_cnt},  {30'd0, sc});
    chk({tag, ".sec_left"},   {24'd0, bus.sec_left},    {24'd0, sl});
  endtask

  // Advance n rising edges and settle 2 time units after the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick_1hz = 1'b1;
      cyc(1);
      bus.tick_1hz = 1'b0;
    end
  endtask

  task automatic pulse_m();
    bus.push_m = 1'b1; cyc(1); bus.push_m = 1'b0;
  endtask

  task automatic pulse_snz();
    bus.push_snooze = 1'b1; cyc(1); bus.push_snooze = 1'b0;
  endtask

  task automatic pulse_done();
    bus.game_done = 1'b1; cyc(1); bus.game_done = 1'b0;
  endtask

  // Produce a fresh rising edge of current == alarm.
  task automatic rematch();
    bus.current = 16'h0731; cyc(1);
    bus.current = 16'h0730; cyc(1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset           = 1'b0;
    bus.tick_1hz    = 1'b0;
    bus.alarm_en    = 1'b0;
    bus.current     = 16'h0729;
    bus.alarm       = 16'h0730;
    bus.push_m      = 1'b0;
    bus.push_snooze = 1'b0;
    bus.game_done   = 1'b0;

    #3;
    chk_all("reset", S_IDLE, 1'b0, 1'b0, 2'd0, 8'd0);
    cyc(2);
    reset = 1'b1;
    cyc(1);
    chk_all("idle_disabled", S_IDLE, 1'b0, 1'b0, 2'd0, 8'd0);

    bus.alarm_en = 1'b1;
    cyc(1);
    chk_all("armed", S_ARMED, 1'b0, 1'b0, 2'd0, 8'd0);
    tick(1);
    chk_all("armed_tick", S_ARMED, 1'b0, 1'b0, 2'd0, 8'd0);

    // 0729 -> 0730 rings on the next edge
    bus.current = 16'h0730;
    cyc(1);
    chk_all("first_ring", S_RING, 1'b1, 1'b0, 2'd0, 8'd10);
    tick(3);
    chk_all("ring_countdown", S_RING, 1'b1, 1'b0, 2'd0, 8'd7);

    // three manual snoozes, each expiring back to RING
    for (int k = 1; k <= 3; k++) begin
      pulse_snz();
      chk_all($sformatf("snooze%0d", k), S_SNOOZE, 1'b0, 1'b0, k[1:0], 8'd5);
      tick(4);
      chk_all($sformatf("snooze%0d_last", k), S_SNOOZE, 1'b0, 1'b0, k[1:0], 8'd1);
      tick(1);
      chk_all($sformatf("snooze%0d_expire", k), S_RING, 1'b1, 1'b0, k[1:0], 8'd10);
    end
    pulse_snz();
    chk_all("snooze4_ignored", S_RING, 1'b1, 1'b0, 2'd3, 8'd10);

    // ring timeout with snoozes exhausted reloads and keeps ringing
    tick(9);
    chk_all("ring_max_last", S_RING, 1'b1, 1'b0, 2'd3, 8'd1);
    tick(1);
    chk_all("ring_max_reload", S_RING, 1'b1, 1'b0, 2'd3, 8'd10);

    // push_m beats push_snooze
    bus.push_m = 1'b1; bus.push_snooze = 1'b1;
    cyc(1);
    bus.push_m = 1'b0; bus.push_snooze = 1'b0;
    chk_all("m_beats_snooze", S_GAME, 1'b0, 1'b1, 2'd3, 8'd30);
    pulse_done();
    chk_all("game_done", S_ARMED, 1'b0, 1'b0, 2'd0, 8'd0);
    cyc(5);
    chk_all("hold_no_rering", S_ARMED, 1'b0, 1'b0, 2'd0, 8'd0);

    // auto-snooze on ring timeout
    rematch();
    chk_all("ring2", S_RING, 1'b1, 1'b0, 2'd0, 8'd10);
    tick(10);
    chk_all("auto_snooze", S_SNOOZE, 1'b0, 1'b0, 2'd1, 8'd5);
    tick(5);
    chk_all("auto_snooze_expire", S_RING, 1'b1, 1'b0, 2'd1, 8'd10);

    // push_m from SNOOZE, pushes ignored in GAME, game timeout
    pulse_snz();
    chk_all("snooze_b", S_SNOOZE, 1'b0, 1'b0, 2'd2, 8'd5);
    tick(2);
    pulse_m();
    chk_all("snooze_to_game", S_GAME, 1'b0, 1'b1, 2'd2, 8'd30);
    pulse_snz();
    pulse_m();
    chk_all("game_ignores_push", S_GAME, 1'b0, 1'b1, 2'd2, 8'd30);
    tick(29);
    chk_all("game_last", S_GAME, 1'b0, 1'b1, 2'd2, 8'd1);
    tick(1);
    chk_all("game_timeout", S_RING, 1'b1, 1'b0, 2'd2, 8'd10);

    // game_done beats game timer expiry
    pulse_m();
    tick(29);
    chk_all("game2_last", S_GAME, 1'b0, 1'b1, 2'd2, 8'd1);
    bus.game_done = 1'b1; bus.tick_1hz = 1'b1;
    cyc(1);
    bus.game_done = 1'b0; bus.tick_1hz = 1'b0;
    chk_all("done_beats_expiry", S_ARMED, 1'b0, 1'b0, 2'd0, 8'd0);

    // alarm_en=0 from RING and from SNOOZE; re-enable with match held high
    rematch();
    chk_all("ring3", S_RING, 1'b1, 1'b0, 2'd0, 8'd10);
    bus.alarm_en = 1'b0;
    cyc(1);
    chk_all("disable_ring", S_IDLE, 1'b0, 1'b0, 2'd0, 8'd0);
    bus.alarm_en = 1'b1;
    cyc(1);
    chk_all("reenable", S_ARMED, 1'b0, 1'b0, 2'd0, 8'd0);
    cyc(3);
    chk_all("reenable_no_ring", S_ARMED, 1'b0, 1'b0, 2'd0, 8'd0);
    rematch();
    pulse_snz();
    chk_all("snooze_c", S_SNOOZE, 1'b0, 1'b0, 2'd1, 8'd5);
    bus.alarm_en = 1'b0;
    cyc(1);
    chk_all("disable_snooze", S_IDLE, 1'b0, 1'b0, 2'd0, 8'd0);

    // asynchronous reset mid-GAME with current == alarm
    bus.alarm_en = 1'b1;
    cyc(1);
    rematch();
    pulse_m();
    chk_all("game_pre_reset", S_GAME, 1'b0, 1'b1, 2'd0, 8'd30);
    #3 reset = 1'b0;
    #1;
    chk_all("async_reset", S_IDLE, 1'b0, 1'b0, 2'd0, 8'd0);
    cyc(2);
    reset = 1'b1;
    cyc(1);
    chk_all("post_reset_armed", S_ARMED, 1'b0, 1'b0, 2'd0, 8'd0);
    cyc(3);
    chk_all("post_reset_no_ring", S_ARMED, 1'b0, 1'b0, 2'd0, 8'd0);
    rematch();
    chk_all("post_reset_rering", S_RING, 1'b1, 1'b0, 2'd0, 8'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alarm_sequencer.md
ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

Interface
REQ-001 SHALL have parameter SNOOZE_SEC, default 8'd5, snooze countdown length in seconds (1..255).
REQ-002 SHALL have parameter MAX_SNOOZE, default 2'd3, maximum snoozes per alarm event (0..3).
REQ-003 SHALL have parameter RING_TIMEOUT, default 8'd10, seconds of unanswered ringing before auto-snooze (1..255).
REQ-004 SHALL have parameter GAME_TIMEOUT, default 8'd30, seconds allowed for the minigame (1..255).
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset; 0 forces reset values immediately.
REQ-007 SHALL have port tick_1hz  input  1  one-clk-wide pulse once per second.
REQ-008 SHALL have port alarm_en  input  1  alarm enable switch (level).
REQ-009 SHALL have port current  input  16  current time, HHMM packed BCD.
REQ-010 SHALL have port alarm  input  16  alarm time, HHMM packed BCD.
REQ-011 SHALL have port push_m  input  1  stop request, one-clk pulse (debounced upstream).
REQ-012 SHALL have port push_snooze  input  1  snooze request, one-clk pulse.
REQ-013 SHALL have port game_done  input  1  minigame success, one-clk pulse.
REQ-014 SHALL have port alarm_state  output  3  current FSM state encoding.
REQ-015 SHALL have port ring  output  1  buzzer/LED enable, high only in RING.
REQ-016 SHALL have port game_en  output  1  minigame enable, high only in GAME.
REQ-017 SHALL have port snooze_cnt  output  2  snoozes taken in current alarm event.
REQ-018 SHALL have port sec_left  output  8  seconds remaining on active timer; 0 when no timer runs.

Function
REQ-019 SHALL implement states IDLE=3'b000, ARMED=3'b001, RING=3'b010, GAME=3'b011, SNOOZE=3'b100; other codes go to IDLE next clk.
REQ-020 SHALL register all outputs; ring/game_en/alarm_state change on the same edge as the state register.
REQ-021 alarm_en=0 SHALL force IDLE, snooze_cnt=0, sec_left=0 on the next edge from any state (highest priority).
REQ-022 IDLE SHALL go to ARMED on the first edge with alarm_en=1.
REQ-023 match = (current==alarm); a registered copy match_d SHALL be kept; ARMED SHALL go to RING only on match & !match_d (rising edge), so one minute of equality triggers once.
REQ-024 On ARMED->IDLE->ARMED re-enable while match already high, SHALL NOT ring until match falls and rises again.
REQ-025 Entering RING SHALL load sec_left=RING_TIMEOUT; entering SNOOZE SHALL load SNOOZE_SEC; entering GAME SHALL load GAME_TIMEOUT.
REQ-026 sec_left SHALL decrement by 1 on each tick_1hz in RING/SNOOZE/GAME, saturating at 0; timer expiry = tick_1hz while sec_left==1.
REQ-027 RING: push_m -> GAME; else push_snooze with snooze_cnt<MAX_SNOOZE -> SNOOZE, snooze_cnt+1; push_snooze with snooze_cnt==MAX_SNOOZE ignored.
REQ-028 RING timer expiry with snooze_cnt<MAX_SNOOZE SHALL act as push_snooze; with snooze_cnt==MAX_SNOOZE SHALL reload RING_TIMEOUT and keep ringing.
REQ-029 Simultaneous push_m and push_snooze (or timer expiry) in RING: push_m SHALL win.
REQ-030 SNOOZE timer expiry SHALL go to RING; push_m in SNOOZE SHALL go to GAME.
REQ-031 GAME: game_done -> ARMED, snooze_cnt=0, sec_left=0; GAME timer expiry -> RING (snooze_cnt unchanged); game_done and expiry same cycle: game_done wins.
REQ-032 Inputs push_m, push_snooze, game_done SHALL be ignored in states where not listed.

Reset
REQ-033 reset=0 SHALL asynchronously set state=IDLE, ring=0, game_en=0, snooze_cnt=0, sec_left=0, match_d=1 (prevents ring on release while current==alarm).
REQ-034 Reset assertion mid-RING/GAME/SNOOZE SHALL abort immediately with no residual ring pulse; release resumes at IDLE.

Verification
REQ-035 alarm_en=1, alarm=16'h0730, current steps 0729->0730 -> RING next edge, ring=1, sec_left=10; holding 0730 after stop never re-rings.
REQ-036 RING, push_snooze x3 each after SNOOZE expiry (5 ticks) -> snooze_cnt=1,2,3; 4th push_snooze ignored, ring stays 1.
REQ-037 RING, no input for 10 ticks -> SNOOZE, snooze_cnt=1, sec_left=5; 5 more ticks -> RING.
REQ-038 RING, push_m and push_snooze same cycle -> GAME, game_en=1, sec_left=30, snooze_cnt unchanged; game_done -> ARMED, snooze_cnt=0.
REQ-039 GAME, 30 ticks without game_done -> RING, sec_left=10; alarm_en=0 at any state -> IDLE, all outputs 0 next edge.
REQ-040 reset pulsed low mid-GAME with current==alarm -> outputs 0 immediately; after release and alarm_en=1, no RING until match re-rises.
